imem_dmem_arbiter: RTL and testbench

- Shares one unified block-oriented main memory between the instruction cache and the data cache.
- Accepts 16-byte block read requests from the instruction cache and block read/write requests from the data cache.
- Issues one memory transaction at a time, round-robin on contention.
- Returns data and busywait to each cache using the caches' existing busywait protocol.
- Memory space: instruction blocks occupy the lower half (region bit 0), data blocks the upper half (region bit 1).

---
 rtl/imem_dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates one block-oriented main memory between the instruction and data caches.
// One memory transaction at a time, round-robin on contention, cache-side busywait handshake.
module imem_dmem_arbiter #(
   parameter int BLK_AW = 6,
   parameter int BLK_W  = 128,
   parameter int MEM_AW = BLK_AW + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_read,
   input  logic [BLK_AW-1:0] i_address,
   output logic [BLK_W-1:0]  i_readdata,
   output logic              i_busywait,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [BLK_AW-1:0] d_address,
   input  logic [BLK_W-1:0]  d_writedata,
   output logic [BLK_W-1:0]  d_readdata,
   output logic              d_busywait,
   output logic              mem_read,
   output logic              mem_write,
   output logic [MEM_AW-1:0] mem_address,
   output logic [BLK_W-1:0]  mem_writedata,
   input  logic [BLK_W-1:0]  mem_readdata,
   input  logic              mem_busywait
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE   = 2'd1,
      RELEASE = 2'd2
   } state_e;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   state_e              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_grant_q, last_grant_d;
   logic                seen_busy_q, seen_busy_d;
   logic                mem_read_q, mem_read_d;
   logic                mem_write_q, mem_write_d;
   logic [MEM_AW-1:0]   mem_address_q, mem_address_d;
   logic [BLK_W-1:0]    mem_writedata_q, mem_writedata_d;
   logic [BLK_W-1:0]    i_readdata_q, i_readdata_d;
   logic [BLK_W-1:0]    d_readdata_q, d_readdata_d;

   logic i_req, d_req, grant;

   assign i_req = i_read;
   assign d_req = d_read | d_write;
   // On contention the port that did not win last time goes first.
   assign grant = (i_req & d_req) ? ~last_grant_q : d_req;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         owner_q         <= OWN_I;
         last_grant_q    <= OWN_D;
         seen_busy_q     <= 1'b0;
         mem_read_q      <= 1'b0;
         mem_write_q     <= 1'b0;
         mem_address_q   <= '0;
         mem_writedata_q <= '0;
         i_readdata_q    <= '0;
         d_readdata_q    <= '0;
      end else begin
         state_q         <= state_d;
         owner_q         <= owner_d;
         last_grant_q    <= last_grant_d;
         seen_busy_q     <= seen_busy_d;
         mem_read_q      <= mem_read_d;
         mem_write_q     <= mem_write_d;
         mem_address_q   <= mem_address_d;
         mem_writedata_q <= mem_writedata_d;
         i_readdata_q    <= i_readdata_d;
         d_readdata_q    <= d_readdata_d;
      end
   end

   // NOTE: every next-state signal is defaulted to its current value first, so no latch is inferred.
   always_comb begin
      state_d         = state_q;
      owner_d         = owner_q;
      last_grant_d    = last_grant_q;
      seen_busy_d     = seen_busy_q;
      mem_read_d      = mem_read_q;
      mem_write_d     = mem_write_q;
      mem_address_d   = mem_address_q;
      mem_writedata_d = mem_writedata_q;
      i_readdata_d    = i_readdata_q;
      d_readdata_d    = d_readdata_q;

      case (state_q)
         IDLE: begin
            if (i_req | d_req) begin
               owner_d     = grant;
               seen_busy_d = 1'b0;
               state_d     = SERVE;
               if (grant == OWN_I) begin
                  mem_read_d    = 1'b1;
                  mem_write_d   = 1'b0;
                  mem_address_d = {1'b0, i_address};
               end else begin
                  mem_address_d = {1'b1, d_address};
                  if (d_write) begin
                     mem_read_d      = 1'b0;
                     mem_write_d     = 1'b1;
                     mem_writedata_d = d_writedata;
                  end else begin
                     mem_read_d  = 1'b1;
                     mem_write_d = 1'b0;
                  end
               end
            end
         end
         SERVE: begin
            // A low busywait only means completion once the memory has shown it accepted the strobe.
            if (mem_busywait) begin
               seen_busy_d = 1'b1;
            end else if (seen_busy_q) begin
               mem_read_d   = 1'b0;
               mem_write_d  = 1'b0;
               last_grant_d = owner_q;
               state_d      = RELEASE;
               if (mem_read_q) begin
                  if (owner_q == OWN_I) i_readdata_d = mem_readdata;
                  else                  d_readdata_d = mem_readdata;
               end
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign i_busywait    = i_req & ~((state_q == RELEASE) & (owner_q == OWN_I));
   assign d_busywait    = d_req & ~((state_q == RELEASE) & (owner_q == OWN_D));
   assign i_readdata    = i_readdata_q;
   assign d_readdata    = d_readdata_q;
   assign mem_read      = mem_read_q;
   assign mem_write     = mem_write_q;
   assign mem_address   = mem_address_q;
   assign mem_writedata = mem_writedata_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter with a small busywait-style memory model.
// Expected values are hand-computed constants or the bench's own memory contents pattern.
module tb_imem_dmem_arbiter;

   localparam int BLK_AW = 6;
   localparam int BLK_W  = 128;
   localparam int MEM_AW = 7;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              i_read = 1'b0;
   logic [BLK_AW-1:0] i_address = '0;
   logic [BLK_W-1:0]  i_readdata;
   logic              i_busywait;
   logic              d_read = 1'b0;
   logic              d_write = 1'b0;
   logic [BLK_AW-1:0] d_address = '0;
   logic [BLK_W-1:0]  d_writedata = '0;
   logic [BLK_W-1:0]  d_readdata;
   logic              d_busywait;
   logic              mem_read;
   logic              mem_write;
   logic [MEM_AW-1:0] mem_address;
   logic [BLK_W-1:0]  mem_writedata;
   logic [BLK_W-1:0]  mem_readdata;
   logic              mem_busywait;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   imem_dmem_arbiter #(.BLK_AW(BLK_AW), .BLK_W(BLK_W), .MEM_AW(MEM_AW)) dut (
      .clock        (clock),
      .reset        (reset),
      .i_read       (i_read),
      .i_address    (i_address),
      .i_readdata   (i_readdata),
      .i_busywait   (i_busywait),
      .d_read       (d_read),
      .d_write      (d_write),
      .d_address    (d_address),
      .d_writedata  (d_writedata),
      .d_readdata   (d_readdata),
      .d_busywait   (d_busywait),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .mem_writedata(mem_writedata),
      .mem_readdata (mem_readdata),
      .mem_busywait (mem_busywait)
   );

   // Memory contents: block k holds byte k replicated, block 5 holds all 4'hA.
   function automatic logic [BLK_W-1:0] pattern(input int k);
      logic [7:0] b;
      b = k[7:0];
      if (k == 5) return {32{4'hA}};
      return {16{b}};
   endfunction

   // Memory model: busy rises on the edge it samples a strobe, stays high lat cycles.
   logic [BLK_W-1:0]  mem_array [0:127];
   int                lat = 5;
   int                cnt;
   logic              done_q;
   logic              cur_is_read;
   logic [MEM_AW-1:0] cur_addr;
   int                tx_count = 0;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_busywait <= 1'b0;
         mem_readdata <= '0;
         done_q       <= 1'b0;
         cnt          <= 0;
         for (int k = 0; k < 128; k++) mem_array[k] <= pattern(k);
      end else if (mem_busywait) begin
         if (cnt <= 1) begin
            mem_busywait <= 1'b0;
            done_q       <= 1'b1;
            if (cur_is_read) mem_readdata <= mem_array[cur_addr];
         end else begin
            cnt <= cnt - 1;
         end
      end else if ((mem_read | mem_write) && !done_q) begin
         mem_busywait <= 1'b1;
         cnt          <= lat;
         cur_is_read  <= mem_read;
         cur_addr     <= mem_address;
         tx_count     <= tx_count + 1;
         if (mem_write) mem_array[mem_address] <= mem_writedata;
      end else if (!(mem_read | mem_write)) begin
         done_q <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [BLK_W-1:0] got, input logic [BLK_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   // Waits (bounded) until the chosen port's busywait drops; a timeout counts as a failure.
   task automatic wait_ready(input string tag, input logic is_d);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
         tick();
         if (!(is_d ? d_busywait : i_busywait)) ok = 1'b1;
      end
      check(tag, ok, 1'b1);
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   int tx0;
   int n_srv;
   int order [6];

   initial begin
      // Reset state
      tick();
      tick();
      check("rst_mem_read", mem_read, 1'b0);
      check("rst_mem_write", mem_write, 1'b0);
      check("rst_mem_address", mem_address, 7'h00);
      check("rst_mem_writedata", mem_writedata, '0);
      check("rst_i_readdata", i_readdata, '0);
      check("rst_d_readdata", d_readdata, '0);
      check("rst_i_busywait", i_busywait, 1'b0);
      check("rst_d_busywait", d_busywait, 1'b0);
      reset = 1'b0;
      tick();

      // Icache only
      tx0 = tx_count;
      i_read = 1'b1; i_address = 6'h05;
      #1 check("t1_stall_same_cycle", i_busywait, 1'b1);
      tick();
      check("t1_mem_read", mem_read, 1'b1);
      check("t1_mem_write", mem_write, 1'b0);
      check("t1_mem_address", mem_address, 7'h05);
      check("t1_d_busywait", d_busywait, 1'b0);
      wait_ready("t1_timeout", 1'b0);
      check("t1_i_readdata", i_readdata, {32{4'hA}});
      check("t1_strobe_dropped", mem_read, 1'b0);
      check("t1_tx_count", tx_count - tx0, 1);
      i_read = 1'b0;
      tick();

      // Dcache write-back
      tx0 = tx_count;
      d_write = 1'b1; d_address = 6'h3F; d_writedata = 128'h1234;
      tick();
      check("t2_mem_write", mem_write, 1'b1);
      check("t2_mem_read", mem_read, 1'b0);
      check("t2_mem_address", mem_address, 7'h7F);
      check("t2_mem_writedata", mem_writedata, 128'h1234);
      wait_ready("t2_timeout", 1'b1);
      check("t2_d_readdata_kept", d_readdata, '0);
      check("t2_strobe_dropped", mem_write, 1'b0);
      d_write = 1'b0;
      tick();
      tick();
      tick();
      check("t2_mem_contents", mem_array[7'h7F], 128'h1234);
      check("t2_tx_count", tx_count - tx0, 1);
      check("t2_idle_no_strobe", mem_write, 1'b0);

      // Simultaneous first requests after reset: icache first
      reset_pulse();
      i_read = 1'b1; i_address = 6'h0A;
      d_read = 1'b1; d_address = 6'h0B;
      #1 check("t3_i_stall", i_busywait, 1'b1);
      check("t3_d_stall", d_busywait, 1'b1);
      tick();
      check("t3_first_addr", mem_address, 7'h0A);
      check("t3_first_read", mem_read, 1'b1);
      wait_ready("t3_i_timeout", 1'b0);
      check("t3_d_still_stalled", d_busywait, 1'b1);
      check("t3_i_readdata", i_readdata, {16{8'h4A}} ^ {16{8'h40}});
      i_read = 1'b0;
      tick();
      check("t3_idle_no_grant", mem_read, 1'b0);
      tick();
      check("t3_second_addr", mem_address, 7'h4B);
      check("t3_second_read", mem_read, 1'b1);
      wait_ready("t3_d_timeout", 1'b1);
      check("t3_d_readdata", d_readdata, {16{8'h4B}});
      d_read = 1'b0;
      tick();

      // Reset two cycles into a dcache read
      d_read = 1'b1; d_address = 6'h12;
      tick();
      check("t6_grant", mem_read, 1'b1);
      tick();
      tick();
      reset = 1'b1;
      #1 check("t6_strobe_async_drop", mem_read, 1'b0);
      check("t6_d_readdata_cleared", d_readdata, '0);
      check("t6_d_busywait_raw", d_busywait, 1'b1);
      tick();
      reset = 1'b0;
      tick();
      check("t6_regrant_read", mem_read, 1'b1);
      check("t6_regrant_addr", mem_address, 7'h52);
      wait_ready("t6_timeout", 1'b1);
      check("t6_d_readdata", d_readdata, {16{8'h52}});
      d_read = 1'b0;
      tick();

      // Back-to-back contention, both re-raised each round
      reset_pulse();
      for (int k = 0; k < 6; k++) order[k] = 2;
      n_srv = 0;
      i_address = 6'h01; d_address = 6'h02;
      i_read = 1'b1; d_read = 1'b1;
      for (int c = 0; c < 300 && n_srv < 6; c++) begin
         tick();
         i_read = 1'b1; d_read = 1'b1;
         #1;
         if (!i_busywait) begin
            order[n_srv] = 0; n_srv++; i_read = 1'b0;
         end else if (!d_busywait) begin
            order[n_srv] = 1; n_srv++; d_read = 1'b0;
         end
      end
      check("t4_rounds", n_srv, 6);
      check("t4_grant0_I", order[0], 0);
      check("t4_grant1_D", order[1], 1);
      check("t4_grant2_I", order[2], 0);
      check("t4_grant3_D", order[3], 1);
      check("t4_grant4_I", order[4], 0);
      check("t4_grant5_D", order[5], 1);
      i_read = 1'b0; d_read = 1'b0;

      // Stale request held through RELEASE only: no double service
      reset_pulse();
      tx0 = tx_count;
      i_read = 1'b1; i_address = 6'h07;
      wait_ready("t5a_timeout", 1'b0);
      check("t5a_i_readdata", i_readdata, {16{8'h07}});
      tick();
      check("t5a_no_regrant", mem_read, 1'b0);
      check("t5a_stalled_again", i_busywait, 1'b1);
      check("t5a_tx_once", tx_count - tx0, 1);
      i_read = 1'b0;
      repeat (10) tick();
      check("t5a_tx_still_once", tx_count - tx0, 1);

      // Held through RELEASE and IDLE: counted as a new request
      i_address = 6'h08;
      i_read = 1'b1;
      wait_ready("t5b_timeout", 1'b0);
      check("t5b_i_readdata", i_readdata, {16{8'h08}});
      tick();
      check("t5b_idle_no_strobe", mem_read, 1'b0);
      tick();
      check("t5b_second_read", mem_read, 1'b1);
      check("t5b_second_addr", mem_address, 7'h08);
      wait_ready("t5b_timeout2", 1'b0);
      check("t5b_tx_total", tx_count - tx0, 3);
      i_read = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
